// File: rtl/vx_wb_commit.sv
// Writeback commit: turns multi-beat writeback sequences into register-file writes and scoreboard releases.
// Optional performance counters are enabled with WB_COMMIT_PERF_EN.
module vx_wb_commit #(
  parameter int ISSUE_WIS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int XLEN        = 32,
  parameter int NR_BITS     = 6,
  parameter int LANE_BITS   = 3,
  localparam int WIS_W      = (ISSUE_WIS > 1) ? $clog2(ISSUE_WIS) : 1,
  localparam int DW         = NUM_THREADS * XLEN
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wb_valid,
  input  logic [WIS_W-1:0]       wb_wis,
  input  logic [NUM_THREADS-1:0] wb_tmask,
  input  logic [NR_BITS-1:0]     wb_rd,
  input  logic [DW-1:0]          wb_data,
  input  logic                   wb_sop,
  input  logic                   wb_eop,
  input  logic                   wb_is_vec,
  input  logic [NR_BITS-1:0]     wb_vd,
  input  logic [LANE_BITS-1:0]   wb_vd_lane_id,
  input  logic                   wb_vd_is_last,
  output logic                   rf_wr_valid,
  output logic [WIS_W-1:0]       rf_wr_wis,
  output logic [NUM_THREADS-1:0] rf_wr_tmask,
  output logic [NR_BITS-1:0]     rf_wr_addr,
  output logic [LANE_BITS-1:0]   rf_wr_lane,
  output logic                   rf_wr_is_vec,
  output logic [DW-1:0]          rf_wr_data,
  output logic                   rel_valid,
  output logic [WIS_W-1:0]       rel_wis,
  output logic [NR_BITS-1:0]     rel_reg,
  output logic                   rel_is_vec,
  output logic [3:0]             proto_err,
  output logic [31:0]            perf_beats,
  output logic [31:0]            perf_instrs
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} slot_state_e;

  slot_state_e          state_q [ISSUE_WIS];
  slot_state_e          state_d [ISSUE_WIS];
  logic                 vec_q   [ISSUE_WIS];
  logic                 vec_d   [ISSUE_WIS];
  logic [NR_BITS-1:0]   dest_q  [ISSUE_WIS];
  logic [NR_BITS-1:0]   dest_d  [ISSUE_WIS];
  logic [LANE_BITS-1:0] lane_q  [ISSUE_WIS];
  logic [LANE_BITS-1:0] lane_d  [ISSUE_WIS];

  logic               do_wr;
  logic               do_rel;
  logic [3:0]         err_set;
  logic [NR_BITS-1:0] beat_dest;
  logic               last_err;

  assign beat_dest = wb_is_vec ? wb_vd : wb_rd;
  assign last_err  = wb_is_vec && (wb_eop != wb_vd_is_last);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    dest_d  = dest_q;
    lane_d  = lane_q;
    do_wr   = 1'b0;
    do_rel  = 1'b0;
    err_set = 4'b0000;
    if (wb_valid) begin
      if (wb_sop) begin
        // An sop on a busy slot abandons the old sequence and starts afresh.
        if (state_q[wb_wis] == S_BUSY) err_set[1] = 1'b1;
        if (last_err) begin
          err_set[3]       = 1'b1;
          state_d[wb_wis]  = S_IDLE;
        end else begin
          do_wr = 1'b1;
          if (wb_eop) begin
            do_rel          = 1'b1;
            state_d[wb_wis] = S_IDLE;
          end else begin
            state_d[wb_wis] = S_BUSY;
            vec_d[wb_wis]   = wb_is_vec;
            dest_d[wb_wis]  = beat_dest;
            lane_d[wb_wis]  = wb_vd_lane_id + LANE_BITS'(1);
          end
        end
      end else if (state_q[wb_wis] == S_IDLE) begin
        err_set[0] = 1'b1;
      end else begin
        if ((wb_is_vec != vec_q[wb_wis]) || (beat_dest != dest_q[wb_wis]) || last_err)
          err_set[3] = 1'b1;
        if (wb_is_vec && (wb_vd_lane_id != lane_q[wb_wis]))
          err_set[2] = 1'b1;
        if (err_set[3:2] != 2'b00) begin
          state_d[wb_wis] = S_IDLE;
        end else begin
          do_wr          = 1'b1;
          lane_d[wb_wis] = lane_q[wb_wis] + LANE_BITS'(1);
          if (wb_eop) begin
            do_rel          = 1'b1;
            state_d[wb_wis] = S_IDLE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ISSUE_WIS; i++) begin
        state_q[i] <= S_IDLE;
        vec_q[i]   <= 1'b0;
        dest_q[i]  <= '0;
        lane_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      dest_q  <= dest_d;
      lane_q  <= lane_d;
    end
  end

  // Data outputs only move on a strobe so they hold between pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rf_wr_valid  <= 1'b0;
      rf_wr_wis    <= '0;
      rf_wr_tmask  <= '0;
      rf_wr_addr   <= '0;
      rf_wr_lane   <= '0;
      rf_wr_is_vec <= 1'b0;
      rf_wr_data   <= '0;
      rel_valid    <= 1'b0;
      rel_wis      <= '0;
      rel_reg      <= '0;
      rel_is_vec   <= 1'b0;
      proto_err    <= 4'b0000;
    end else begin
      rf_wr_valid <= do_wr;
      rel_valid   <= do_rel;
      proto_err   <= proto_err | err_set;
      if (do_wr) begin
        rf_wr_wis    <= wb_wis;
        rf_wr_tmask  <= wb_tmask;
        rf_wr_addr   <= beat_dest;
        rf_wr_lane   <= wb_is_vec ? wb_vd_lane_id : '0;
        rf_wr_is_vec <= wb_is_vec;
        rf_wr_data   <= wb_data;
      end
      if (do_rel) begin
        rel_wis    <= wb_wis;
        rel_reg    <= beat_dest;
        rel_is_vec <= wb_is_vec;
      end
    end
  end

`ifdef WB_COMMIT_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_beats  <= '0;
      perf_instrs <= '0;
    end else begin
      if (do_wr)  perf_beats  <= perf_beats + 32'd1;
      if (do_rel) perf_instrs <= perf_instrs + 32'd1;
    end
  end
`else
  assign perf_beats  = 32'd0;
  assign perf_instrs = 32'd0;
`endif

endmodule

// File: tb/tb_vx_wb_commit.sv
// Directed bench for vx_wb_commit: expected writes/releases are queued as beats are driven
// and popped when the strobes appear; sticky errors, hold behaviour and counters are checked directly.
module tb_vx_wb_commit;
  localparam int ISSUE_WIS   = 4;
  localparam int NUM_THREADS = 4;
  localparam int XLEN        = 32;
  localparam int NR_BITS     = 6;
  localparam int LANE_BITS   = 3;
  localparam int WIS_W       = 2;
  localparam int DW          = NUM_THREADS * XLEN;
  localparam int WR_W        = WIS_W + NUM_THREADS + NR_BITS + LANE_BITS + 1 + DW;
  localparam int REL_W       = WIS_W + NR_BITS + 1;

  logic                   clk;
  logic                   reset;
  logic                   wb_valid;
  logic [WIS_W-1:0]       wb_wis;
  logic [NUM_THREADS-1:0] wb_tmask;
  logic [NR_BITS-1:0]     wb_rd;
  logic [DW-1:0]          wb_data;
  logic                   wb_sop, wb_eop, wb_is_vec;
  logic [NR_BITS-1:0]     wb_vd;
  logic [LANE_BITS-1:0]   wb_vd_lane_id;
  logic                   wb_vd_is_last;
  logic                   rf_wr_valid;
  logic [WIS_W-1:0]       rf_wr_wis;
  logic [NUM_THREADS-1:0] rf_wr_tmask;
  logic [NR_BITS-1:0]     rf_wr_addr;
  logic [LANE_BITS-1:0]   rf_wr_lane;
  logic                   rf_wr_is_vec;
  logic [DW-1:0]          rf_wr_data;
  logic                   rel_valid;
  logic [WIS_W-1:0]       rel_wis;
  logic [NR_BITS-1:0]     rel_reg;
  logic                   rel_is_vec;
  logic [3:0]             proto_err;
  logic [31:0]            perf_beats, perf_instrs;

  logic [WR_W-1:0]  wr_q[$];
  logic [REL_W-1:0] rel_q[$];
  int tests = 0;
  int fails = 0;
  int n_wr  = 0;
  int n_rel = 0;

  vx_wb_commit #(
    .ISSUE_WIS(ISSUE_WIS), .NUM_THREADS(NUM_THREADS), .XLEN(XLEN),
    .NR_BITS(NR_BITS), .LANE_BITS(LANE_BITS)
  ) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_wis(wb_wis), .wb_tmask(wb_tmask),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_sop(wb_sop), .wb_eop(wb_eop), .wb_is_vec(wb_is_vec),
    .wb_vd(wb_vd), .wb_vd_lane_id(wb_vd_lane_id), .wb_vd_is_last(wb_vd_is_last),
    .rf_wr_valid(rf_wr_valid), .rf_wr_wis(rf_wr_wis), .rf_wr_tmask(rf_wr_tmask),
    .rf_wr_addr(rf_wr_addr), .rf_wr_lane(rf_wr_lane), .rf_wr_is_vec(rf_wr_is_vec),
    .rf_wr_data(rf_wr_data), .rel_valid(rel_valid), .rel_wis(rel_wis), .rel_reg(rel_reg),
    .rel_is_vec(rel_is_vec), .proto_err(proto_err), .perf_beats(perf_beats),
    .perf_instrs(perf_instrs)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_perf(input int n);
`ifdef WB_COMMIT_PERF_EN
    return 32'(n);
`else
    return 32'(0 * n);
`endif
  endfunction

  // Driver tasks
  task automatic beat(input logic [WIS_W-1:0] wis, input logic [NUM_THREADS-1:0] tm,
                      input logic [NR_BITS-1:0] rd, input logic sop, input logic eop,
                      input logic isv, input logic [NR_BITS-1:0] vd,
                      input logic [LANE_BITS-1:0] lane, input logic last,
                      input logic ew, input logic er);
    logic [DW-1:0]        d;
    logic [NR_BITS-1:0]   a;
    logic [LANE_BITS-1:0] l;
    d = {$urandom, $urandom, $urandom, $urandom};
    a = isv ? vd : rd;
    l = isv ? lane : '0;
    @(negedge clk);
    wb_valid = 1'b1; wb_wis = wis; wb_tmask = tm; wb_rd = rd; wb_data = d;
    wb_sop = sop; wb_eop = eop; wb_is_vec = isv; wb_vd = vd;
    wb_vd_lane_id = lane; wb_vd_is_last = last;
    if (ew) begin
      wr_q.push_back({wis, tm, a, l, isv, d});
      n_wr++;
    end
    if (er) begin
      rel_q.push_back({wis, a, isv});
      n_rel++;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    wb_valid = 1'b0;
    wb_sop   = 1'b0;
    wb_eop   = 1'b0;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard
  always @(posedge clk) begin
    #1;
    if (rf_wr_valid === 1'b1) begin
      if (wr_q.size() == 0) begin
        tests++; fails++;
        $error("FAIL wr_unexpected: observed write addr %0d expected none", rf_wr_addr);
      end else begin
        check("wr", {rf_wr_wis, rf_wr_tmask, rf_wr_addr, rf_wr_lane, rf_wr_is_vec, rf_wr_data},
              wr_q.pop_front());
      end
    end
    if (rel_valid === 1'b1) begin
      if (rel_q.size() == 0) begin
        tests++; fails++;
        $error("FAIL rel_unexpected: observed release reg %0d expected none", rel_reg);
      end else begin
        check("rel", {rel_wis, rel_reg, rel_is_vec}, rel_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b0; wb_valid = 1'b0; wb_wis = '0; wb_tmask = '0; wb_rd = '0; wb_data = '0;
    wb_sop = 1'b0; wb_eop = 1'b0; wb_is_vec = 1'b0; wb_vd = '0; wb_vd_lane_id = '0;
    wb_vd_is_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_valid", rf_wr_valid, 0);
    check("rst_rel_valid", rel_valid, 0);
    check("rst_proto_err", proto_err, 0);
    check("rst_wr_addr", rf_wr_addr, 0);
    check("rst_wr_data", rf_wr_data, 0);
    check("rst_perf_beats", perf_beats, 0);
    @(negedge clk);
    reset = 1'b1;

    // Scalar single beat
    beat(2'd1, 4'b1011, 6'd5, 1'b1, 1'b1, 1'b0, 6'd33, 3'd3, 1'b0, 1'b1, 1'b1);
    idle();
    settle();
    check("hold_wr_valid", rf_wr_valid, 0);
    check("hold_wr_addr", rf_wr_addr, 5);
    check("hold_rel_reg", rel_reg, 5);

    // Vector 4-lane write
    for (int i = 0; i < 4; i++)
      beat(2'd2, 4'hf, 6'd7, i == 0, i == 3, 1'b1, 6'd9, LANE_BITS'(i), i == 3, 1'b1, i == 3);
    idle();

    // Interleaved vector writes on slots 0 and 3
    for (int i = 0; i < 3; i++) begin
      beat(2'd0, 4'hf, 6'd0, i == 0, i == 2, 1'b1, 6'd10, LANE_BITS'(i), i == 2, 1'b1, i == 2);
      beat(2'd3, 4'h3, 6'd0, i == 0, i == 2, 1'b1, 6'd11, LANE_BITS'(i), i == 2, 1'b1, i == 2);
    end
    idle();
    settle();
    check("interleave_err", proto_err, 0);

    // Back-to-back scalar beats, then a two-beat scalar sequence
    beat(2'd0, 4'h1, 6'd1, 1'b1, 1'b1, 1'b0, 6'd0, 3'd0, 1'b0, 1'b1, 1'b1);
    beat(2'd0, 4'h2, 6'd2, 1'b1, 1'b1, 1'b0, 6'd0, 3'd0, 1'b0, 1'b1, 1'b1);
    beat(2'd0, 4'h4, 6'd3, 1'b1, 1'b1, 1'b0, 6'd0, 3'd0, 1'b0, 1'b1, 1'b1);
    beat(2'd1, 4'hf, 6'd20, 1'b1, 1'b0, 1'b0, 6'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    beat(2'd1, 4'hf, 6'd20, 1'b0, 1'b1, 1'b0, 6'd0, 3'd0, 1'b0, 1'b1, 1'b1);
    idle();
    settle();
    check("scalar_err", proto_err, 0);
    check("perf_beats_mid", perf_beats, exp_perf(n_wr));
    check("perf_instrs_mid", perf_instrs, exp_perf(n_rel));

    // Out-of-order lane, then slot must be idle and accept a fresh sop
    beat(2'd0, 4'hf, 6'd0, 1'b1, 1'b0, 1'b1, 6'd4, 3'd0, 1'b0, 1'b1, 1'b0);
    beat(2'd0, 4'hf, 6'd0, 1'b0, 1'b0, 1'b1, 6'd4, 3'd2, 1'b0, 1'b0, 1'b0);
    idle();
    settle();
    check("ooo_lane_err", proto_err, 4'b0100);
    beat(2'd0, 4'h5, 6'd8, 1'b1, 1'b1, 1'b0, 6'd0, 3'd0, 1'b0, 1'b1, 1'b1);
    beat(2'd0, 4'h5, 6'd8, 1'b0, 1'b1, 1'b0, 6'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    idle();
    settle();
    check("idle_nosop_err", proto_err, 4'b0101);

    // eop disagreeing with vd_is_last
    beat(2'd2, 4'hf, 6'd0, 1'b1, 1'b0, 1'b1, 6'd12, 3'd0, 1'b0, 1'b1, 1'b0);
    beat(2'd2, 4'hf, 6'd0, 1'b0, 1'b1, 1'b1, 6'd12, 3'd1, 1'b0, 1'b0, 1'b0);
    idle();
    settle();
    check("last_mismatch_err", proto_err, 4'b1101);

    // sop on a busy slot aborts and restarts
    beat(2'd3, 4'hf, 6'd0, 1'b1, 1'b0, 1'b1, 6'd13, 3'd0, 1'b0, 1'b1, 1'b0);
    beat(2'd3, 4'h9, 6'd14, 1'b1, 1'b1, 1'b0, 6'd0, 3'd0, 1'b0, 1'b1, 1'b1);
    idle();
    settle();
    check("sop_busy_err", proto_err, 4'b1111);
    check("perf_beats_pre", perf_beats, exp_perf(n_wr));
    check("perf_instrs_pre", perf_instrs, exp_perf(n_rel));

    // Reset in the middle of a vector sequence; beat during reset is ignored
    beat(2'd1, 4'hf, 6'd0, 1'b1, 1'b0, 1'b1, 6'd6, 3'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    wb_valid = 1'b1; wb_sop = 1'b1; wb_eop = 1'b1; wb_is_vec = 1'b0; wb_rd = 6'd30;
    n_wr = 0;
    n_rel = 0;
    settle();
    check("midrst_err", proto_err, 0);
    check("midrst_wr_addr", rf_wr_addr, 0);
    check("midrst_perf_beats", perf_beats, 0);
    @(negedge clk);
    reset = 1'b1;
    wb_valid = 1'b0;
    beat(2'd1, 4'hf, 6'd0, 1'b0, 1'b0, 1'b1, 6'd6, 3'd1, 1'b0, 1'b0, 1'b0);
    idle();
    settle();
    check("post_rst_err", proto_err, 4'b0001);
    check("post_rst_perf_beats", perf_beats, exp_perf(n_wr));
    check("post_rst_wr_valid", rf_wr_valid, 0);

    repeat (3) @(posedge clk);
    #2;
    check("wr_q_left", wr_q.size(), 0);
    check("rel_q_left", rel_q.size(), 0);

    // Final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
